// File: rtl/soc_pm_cfg_sequencer.sv
// Pixel-matrix digital-config loader: shifts a 32-bit snapshot out MSB-first on a
// divided serial clock, strobes the chain latch, then updates the applied outputs.
module soc_pm_cfg_sequencer #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        sh_clk,
  output logic        sh_data,
  output logic        sh_load,
  output logic [25:0] res,
  output logic [2:0]  num_bit_sel,
  output logic        lc_mode,
  output logic        limit_enable,
  output logic        sample_mode
);

  // state    | meaning
  // IDLE     | waiting for start
  // SHIFT_LO | sh_clk low, sh_data presents current bit
  // SHIFT_HI | sh_clk high, matrix samples sh_data
  // LATCH    | sh_load strobe for CLK_DIV cycles
  // DONE     | one-cycle completion pulse, applied outputs just updated
  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;

  localparam logic [7:0] PH_MAX = 8'(CLK_DIV - 1);

  state_t      state, state_nxt;
  logic [31:0] shadow, shift_reg, applied, out_word;
  logic [7:0]  phase;
  logic [4:0]  bit_cnt;
  logic        phase_end;

  assign phase_end = (phase == PH_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = SHIFT_LO;
      SHIFT_LO: if (phase_end) state_nxt = SHIFT_HI;
      SHIFT_HI: if (phase_end) state_nxt = (bit_cnt == 5'd31) ? LATCH : SHIFT_LO;
      LATCH:    if (phase_end) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    sh_clk  = 1'b0;
    sh_data = 1'b0;
    sh_load = 1'b0;
    case (state)
      SHIFT_LO: begin
        busy    = 1'b1;
        sh_data = shift_reg[31];
      end
      SHIFT_HI: begin
        busy    = 1'b1;
        sh_clk  = 1'b1;
        sh_data = shift_reg[31];
      end
      LATCH: begin
        busy    = 1'b1;
        sh_load = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      shift_reg <= '0;
      applied   <= '0;
      out_word  <= '0;
      phase     <= '0;
      bit_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (cfg_we) shadow <= cfg_wdata;
      phase <= (state_nxt != state || state == IDLE) ? 8'd0 : phase + 8'd1;
      case (state)
        IDLE: if (start) begin
          // same-cycle write goes straight to the chain as well as the shadow
          shift_reg <= cfg_we ? cfg_wdata : shadow;
          applied   <= cfg_we ? cfg_wdata : shadow;
          bit_cnt   <= '0;
        end
        SHIFT_HI: if (phase_end) begin
          shift_reg <= {shift_reg[30:0], 1'b0};
          if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
        end
        LATCH: if (phase_end) out_word <= applied;
        default: ;
      endcase
    end
  end

  assign cfg_rdata    = shadow;
  assign res          = out_word[25:0];
  assign num_bit_sel  = out_word[28:26];
  assign lc_mode      = out_word[29];
  assign limit_enable = out_word[30];
  assign sample_mode  = out_word[31];

endmodule

// File: tb/tb_soc_pm_cfg_sequencer.sv
// Bench for soc_pm_cfg_sequencer: two instances (CLK_DIV=2 and 1) share stimulus and
// are checked every cycle against an offset-based timing model plus literal checks.
module tb_soc_pm_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [31:0] cfg_wdata = '0;
  logic        start = 1'b0;

  logic [31:0] rdata_w [2];
  logic        busy_w [2], done_w [2], shc_w [2], shd_w [2], shl_w [2];
  logic [25:0] res_w [2];
  logic [2:0]  nbs_w [2];
  logic        lc_w [2], le_w [2], sm_w [2];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;

  // model: per instance, active load with offset d since the accepting edge
  logic        m_active [2];
  int          m_d [2];
  logic [31:0] m_word [2];
  logic [31:0] m_out [2];
  logic [31:0] m_shadow;

  // trackers for literal checks
  int          done_cnt [2], done_cyc [2], nedge [2];
  logic [31:0] bits [2];
  logic        prev_clk [2];

  always #5 clk = ~clk;

  soc_pm_cfg_sequencer #(.CLK_DIV(2)) u_dut0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata), .cfg_rdata(rdata_w[0]),
    .start(start), .busy(busy_w[0]), .done(done_w[0]), .sh_clk(shc_w[0]),
    .sh_data(shd_w[0]), .sh_load(shl_w[0]), .res(res_w[0]), .num_bit_sel(nbs_w[0]),
    .lc_mode(lc_w[0]), .limit_enable(le_w[0]), .sample_mode(sm_w[0]));

  soc_pm_cfg_sequencer #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata), .cfg_rdata(rdata_w[1]),
    .start(start), .busy(busy_w[1]), .done(done_w[1]), .sh_clk(shc_w[1]),
    .sh_data(shd_w[1]), .sh_load(shl_w[1]), .res(res_w[1]), .num_bit_sel(nbs_w[1]),
    .lc_mode(lc_w[1]), .limit_enable(le_w[1]), .sample_mode(sm_w[1]));

  function automatic int cd_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] out_of(input int i);
    return {sm_w[i], le_w[i], lc_w[i], nbs_w[i], res_w[i]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] = 1'b0;
        m_d[i]      = 0;
        m_word[i]   = '0;
        m_out[i]    = '0;
      end
      m_shadow = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_active[i]) begin
          if (start) begin
            m_active[i] = 1'b1;
            m_d[i]      = 0;
            m_word[i]   = cfg_we ? cfg_wdata : m_shadow;
          end
        end else begin
          m_d[i] = m_d[i] + 1;
          if (m_d[i] == 65 * cd_of(i)) m_out[i] = m_word[i];
          else if (m_d[i] > 65 * cd_of(i)) m_active[i] = 1'b0;
        end
      end
      if (cfg_we) m_shadow = cfg_wdata;
    end
  end

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic [4:0] exp_ctl, act_ctl;
      int cd, d;
      cd = cd_of(i);
      exp_ctl = '0;
      if (m_active[i]) begin
        d = m_d[i];
        if (d < 64 * cd) begin
          exp_ctl[4] = 1'b1;
          exp_ctl[2] = ((d % (2 * cd)) >= cd);
          exp_ctl[1] = m_word[i][31 - d / (2 * cd)];
        end else if (d < 65 * cd) begin
          exp_ctl[4] = 1'b1;
          exp_ctl[0] = 1'b1;
        end else begin
          exp_ctl[3] = 1'b1;
        end
      end
      act_ctl = {busy_w[i], done_w[i], shc_w[i], shd_w[i], shl_w[i]};
      vectors++;
      if (act_ctl !== exp_ctl || out_of(i) !== m_out[i] || rdata_w[i] !== m_shadow) begin
        miscompares++;
        if (miscompares < 30)
          $display("FAIL cycle%0d dut%0d {busy,done,clk,data,load}/out/rdata: got %b/%h/%h want %b/%h/%h",
                   cyc, i, act_ctl, out_of(i), rdata_w[i], exp_ctl, m_out[i], m_shadow);
      end
      if (done_w[i] === 1'b1) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
      end
      if (shc_w[i] === 1'b1 && prev_clk[i] === 1'b0) begin
        nedge[i]++;
        bits[i] = {bits[i][30:0], shd_w[i]};
      end
      prev_clk[i] = shc_w[i];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input logic we, input logic [31:0] wd, input logic st);
    @(negedge clk);
    cyc++;
    check_all();
    cfg_we    = we;
    cfg_wdata = wd;
    start     = st;
    if (st) start_cyc = cyc;
  endtask

  task automatic clear_trk();
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0;
      done_cyc[i] = -1;
      nedge[i]    = 0;
      bits[i]     = '0;
      prev_clk[i] = shc_w[i];
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    // reset
    clear_trk();
    idle(3);
    rst = 1'b0;
    idle(2);
    chk("reset rdata", rdata_w[0], 32'h0);
    chk("reset out", out_of(0), 32'h0);

    // basic load
    tick(1'b1, 32'hA5A5_1234, 1'b0);
    clear_trk();
    tick(1'b0, 32'h0, 1'b1);
    idle(140);
    chk("basic done latency div2", 32'(done_cyc[0] - start_cyc), 32'd131);
    chk("basic done latency div1", 32'(done_cyc[1] - start_cyc), 32'd66);
    chk("basic sh_clk edges", 32'(nedge[0]), 32'd32);
    chk("basic chain bits", bits[0], 32'hA5A5_1234);
    chk("basic res", 32'(res_w[0]), 32'h01A5_1234);
    chk("basic num_bit_sel", 32'(nbs_w[0]), 32'd1);
    chk("basic lc/limit/sample", 32'({lc_w[0], le_w[0], sm_w[0]}), 32'b101);

    // write during busy
    tick(1'b1, 32'hFFFF_FFFF, 1'b0);
    clear_trk();
    tick(1'b0, 32'h0, 1'b1);
    for (int k = 1; k <= 140; k++) tick(k == 40, 32'h0, 1'b0);
    chk("wbusy chain bits", bits[0], 32'hFFFF_FFFF);
    chk("wbusy applied", out_of(0), 32'hFFFF_FFFF);
    chk("wbusy rdata", rdata_w[0], 32'h0);

    // start while busy and in the DONE cycle
    tick(1'b1, 32'h1357_9BDF, 1'b0);
    clear_trk();
    tick(1'b0, 32'h0, 1'b1);
    for (int k = 1; k <= 135; k++) tick(1'b0, 32'h0, (k == 20) || (k == 131));
    chk("ignored start done count", 32'(done_cnt[0]), 32'd1);
    chk("ignored start edges", 32'(nedge[0]), 32'd32);
    idle(80);

    // same-cycle write and start
    tick(1'b1, 32'h0, 1'b0);
    clear_trk();
    tick(1'b1, 32'h8000_0001, 1'b1);
    idle(140);
    chk("wthru chain bits", bits[0], 32'h8000_0001);
    chk("wthru sample_mode", 32'(sm_w[0]), 32'd1);
    chk("wthru res", 32'(res_w[0]), 32'd1);

    // reset mid-shift at bit 10, then reload
    clear_trk();
    tick(1'b1, 32'hDEAD_BEEF, 1'b1);
    idle(42);
    @(negedge clk);
    cyc++;
    check_all();
    cfg_we = 1'b0;
    start  = 1'b0;
    rst    = 1'b1;
    #1;
    chk("abort sh_clk", 32'(shc_w[0]), 32'd0);
    chk("abort busy", 32'(busy_w[0]), 32'd0);
    chk("abort applied", out_of(0), 32'h0);
    idle(2);
    rst = 1'b0;
    idle(2);
    clear_trk();
    tick(1'b1, 32'h1234_5678, 1'b1);
    idle(140);
    chk("reload done latency div1", 32'(done_cyc[1] - start_cyc), 32'd66);
    chk("reload done latency div2", 32'(done_cyc[0] - start_cyc), 32'd131);
    chk("reload chain div1", bits[1], 32'h1234_5678);
    chk("reload applied div1", out_of(1), 32'h1234_5678);

    // randomized traffic against the model
    for (int k = 0; k < 1500; k++)
      tick($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 15) == 0);
    idle(140);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/soc_pm_cfg_sequencer.md
# soc_pm_cfg_sequencer

Sequencer that loads the pixel-matrix digital configuration (res, num_bit_sel, lc_mode, limit_enable, sample_mode) into the matrix over its serial configuration chain. Software writes a 32-bit shadow word, then pulses start. The block shifts the snapshot out MSB-first with a divided shift clock, pulses the chain latch, and then updates its parallel digital-config outputs. It sits between the SoC peripheral register bank and the pixel-matrix digital-config interface, driving the master side.

## Interface

- CLK_DIV, default 2: shift-clock half-period in clk cycles; legal range 1..255.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_we  input  1  write strobe for the shadow word.
- cfg_wdata  input  32  shadow word: [25:0] res, [28:26] num_bit_sel, [29] lc_mode, [30] limit_enable, [31] sample_mode.
- cfg_rdata  output  32  current shadow word (readback).
- start  input  1  single-cycle request to load the shadow word into the matrix.
- busy  output  1  high while shifting or latching.
- done  output  1  one-cycle pulse when a load completes.
- sh_clk  output  1  serial chain clock to the matrix.
- sh_data  output  1  serial chain data, MSB first.
- sh_load  output  1  chain latch strobe.
- res  output  26  applied digital config.
- num_bit_sel  output  3  applied digital config.
- lc_mode  output  1  applied digital config.
- limit_enable  output  1  applied digital config.
- sample_mode  output  1  applied digital config.

## Operation

- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE.
- **Shadow register.** cfg_we writes the shadow word in any state. A write during busy changes only the shadow, never the in-flight shift.
- **IDLE.**
  - If start=1: copy the shadow into the 32-bit shift register, with the same-cycle cfg_wdata taking precedence when cfg_we=1 (write-through).
  - Then clear the bit counter to 0 and go to SHIFT_LO.
  - start in any other state is ignored and has no side effect.
- **SHIFT_LO.** sh_clk=0, sh_data=shift[31]. Hold for CLK_DIV cycles, then go to SHIFT_HI.
- **SHIFT_HI.**
  - sh_clk=1, sh_data held. Hold for CLK_DIV cycles.
  - On exit: shift left by 1 and increment the bit counter.
  - If the counter was 31, go to LATCH; otherwise go to SHIFT_LO.
- **LATCH.** sh_clk=0, sh_load=1 for CLK_DIV cycles. On exit, go to DONE.
- **DONE.**
  - On entry, copy the snapshot word (retained in a separate 32-bit applied register) into res/num_bit_sel/lc_mode/limit_enable/sample_mode.
  - done=1 for exactly one cycle, then go to IDLE.
- busy = 1 in SHIFT_LO, SHIFT_HI and LATCH; 0 in IDLE and DONE.
- Phase counter: 8 bits, counts 0..CLK_DIV-1, cleared on every state change.
- Bit counter: 5 bits, 0..31, no wrap beyond 31.

## Timing

- **Reset values.** All outputs, the shadow, the shift and applied registers, and both counters are 0; state is IDLE. Reset takes effect immediately (asynchronous) and releases synchronously to the FSM.
- **Reset mid-load.** The load aborts and sh_clk/sh_load drop to 0 at once. The matrix chain contents are then undefined; software reissues start.
- **Start latency.** start sampled at edge N gives busy=1 and the first sh_data valid after edge N.
- **Per bit.** 2·CLK_DIV cycles. Matrix samples sh_data on the rising edge of sh_clk, with CLK_DIV cycles of setup and hold.
- **Total.** done is high in cycle N+65·CLK_DIV+1. With CLK_DIV=2, done is high in cycle N+131, and busy is high for 130 cycles.
- **Applied outputs.** Change in the same cycle done is high. They are never glitched mid-shift.
- **start during DONE.** Ignored. The earliest accepted restart is the cycle after done.
- **Simultaneous cfg_we and start in IDLE.** The new data is both stored and shifted.

## Test plan

- **Reset.** Assert rst mid-simulation, then release -> all outputs 0, cfg_rdata=0, state IDLE.
- **Basic load, CLK_DIV=2.** Write 0xA5A5_1234, pulse start at cycle N. Required response:
  - 32 sh_clk rising edges, each 4 cycles apart, with sampled bits equal to 0xA5A5_1234 MSB first.
  - sh_load high for 2 cycles.
  - done at N+131.
  - res=0x1A51234, num_bit_sel=1, lc_mode=1, limit_enable=0, sample_mode=1.
- **Write during busy.** Load 0xFFFF_FFFF. Mid-shift, write 0x0000_0000 -> chain still receives all ones. Applied outputs end at all ones. cfg_rdata=0.
- **start while busy, and in the DONE cycle.** Both ignored: exactly one done pulse and 32 sh_clk edges.
- **Same-cycle write and start.** In IDLE with shadow 0, cfg_we=1 with 0x8000_0001 plus start -> chain receives 0x8000_0001. sample_mode=1, res=1.
- **Reset mid-shift, then CLK_DIV=1.** Abort at bit 10 -> sh_clk=0 immediately, applied outputs 0. A subsequent load of 0x1234_5678 completes with done at N+66.
